// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// State encoding is fixed at 2 bits; grant owner is a single bit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_WAIT = 2'b01,
    DM_WAIT = 2'b10,
    ERR_RSP = 2'b11
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Halfword accesses must be even; the address LSB flags a misaligned access.
  function automatic logic is_misaligned(input logic addr_lsb);
    return addr_lsb;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch stage
// (read-only) and the memory stage (load/store). One transaction at a time,
// data side has fixed priority, issued address/data/wr are latched so the
// requesters may change their inputs mid-transaction.
// Optional feature: define MEM_ARB_ALIGN_CHK_EN to reject odd addresses with
// a one-cycle error response (no memory access is issued).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  import mem_arb_pkg::*;

  arb_state_t        state;
  arb_state_t        state_nxt;

  logic              gnt_valid;
  logic              gnt_owner;
  logic              gnt_err;
  logic              gnt_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

`ifdef MEM_ARB_ALIGN_CHK_EN
  // Remembers who gets the error response, since no WAIT state encodes it.
  logic              err_owner;
`endif

  // Grant selection: only IDLE grants; data request wins over fetch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = GNT_IF;
    gnt_addr  = if_addr;
    gnt_wr    = 1'b0;
    gnt_wdata = mem_wdata;
    if (state == IDLE) begin
      if (dm_req) begin
        gnt_valid = 1'b1;
        gnt_owner = GNT_DM;
        gnt_addr  = dm_addr;
        gnt_wr    = dm_wr;
        gnt_wdata = dm_wdata;
      end else if (if_req) begin
        gnt_valid = 1'b1;
      end else begin
        gnt_valid = 1'b0;
      end
    end else begin
      gnt_valid = 1'b0;
    end
  end

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign gnt_err = gnt_valid & is_misaligned(gnt_addr[0]);
`else
  assign gnt_err = 1'b0;
`endif

  // Next-state logic: one transaction per visit, always back through IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt_err) begin
            state_nxt = ERR_RSP;
          end else if (gnt_owner == GNT_DM) begin
            state_nxt = DM_WAIT;
          end else begin
            state_nxt = IF_WAIT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (mem_done) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state;
        end
      end
      ERR_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue registers: strobe for one cycle, address/data/wr held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= gnt_valid & ~gnt_err;
      if (gnt_valid & ~gnt_err) begin
        mem_wr    <= gnt_wr;
        mem_addr  <= gnt_addr;
        mem_wdata <= gnt_wdata;
      end
    end
  end

`ifdef MEM_ARB_ALIGN_CHK_EN
  // Capture the owner of a rejected access for the error response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_owner <= GNT_IF;
    end else if (gnt_valid) begin
      err_owner <= gnt_owner;
    end
  end
`endif

  // Completion outputs follow mem_done combinationally so done lands in the same cycle.
  always_comb begin
    if_done  = 1'b0;
    dm_done  = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    err      = 1'b0;
    case (state)
      IF_WAIT: begin
        if (mem_done) begin
          if_done  = 1'b1;
          if_rdata = mem_rdata;
        end else begin
          if_done  = 1'b0;
        end
      end
      DM_WAIT: begin
        if (mem_done) begin
          dm_done  = 1'b1;
          dm_rdata = mem_rdata;
        end else begin
          dm_done  = 1'b0;
        end
      end
      ERR_RSP: begin
`ifdef MEM_ARB_ALIGN_CHK_EN
        err = 1'b1;
        if (err_owner == GNT_DM) begin
          dm_done = 1'b1;
        end else begin
          if_done = 1'b1;
        end
`else
        err = 1'b0;
`endif
      end
      default: err = 1'b0;
    endcase
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of requesters and memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = 16'h0000;
  logic [15:0] dm_wdata = 16'h0000;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_done = 1'b0;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [15:0] mm [0:255];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'hFFFF;
    smp();
    checks++; if ({mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, err} !== 52'd0) begin
      errors++; $display("FAIL reset_outputs: got en=%b wr=%b addr=%h wd=%h ifd=%b dmd=%b err=%b, want all 0", mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, err);
    end
    checks++; if ({if_stall, dm_stall} !== 2'b10) begin
      errors++; $display("FAIL reset_stalls: got %b%b want 10", if_stall, dm_stall);
    end
    cyc(); rst = 1'b0; if_req = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0000;
    smp();
    cyc(); smp();
  endtask

  task automatic test_if_basic();
    cyc(); if_req = 1'b1; if_addr = 16'h0000; smp();
    checks++; if ({mem_en, if_stall} !== 2'b01) begin
      errors++; $display("FAIL if_c0: got en=%b stall=%b want 0 1", mem_en, if_stall);
    end
    cyc(); smp();
    checks++; if ({mem_en, mem_wr, mem_addr, if_done} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL if_issue: got en=%b wr=%b addr=%h done=%b want 1 0 0000 0", mem_en, mem_wr, mem_addr, if_done);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'h1234; smp();
    checks++; if ({if_done, if_rdata, if_stall, mem_en} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
      errors++; $display("FAIL if_done: got done=%b rdata=%h stall=%b en=%b want 1 1234 0 0", if_done, if_rdata, if_stall, mem_en);
    end
    cyc(); if_req = 1'b0; mem_done = 1'b0; smp();
    checks++; if ({if_done, mem_en} !== 2'b00) begin
      errors++; $display("FAIL if_after: got done=%b en=%b want 0 0", if_done, mem_en);
    end
  endtask

  task automatic test_priority();
    cyc(); if_req = 1'b1; if_addr = 16'h0000; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010; smp();
    cyc(); smp();
    checks++; if ({mem_en, mem_wr, mem_addr, if_stall} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
      errors++; $display("FAIL prio_dm_issue: got en=%b wr=%b addr=%h ifstall=%b want 1 0 0010 1", mem_en, mem_wr, mem_addr, if_stall);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'h5A5A; smp();
    checks++; if ({dm_done, dm_rdata, if_done, if_stall, dm_stall} !== {1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL prio_dm_done: got dmd=%b rd=%h ifd=%b ifst=%b dmst=%b want 1 5a5a 0 1 0", dm_done, dm_rdata, if_done, if_stall, dm_stall);
    end
    cyc(); dm_req = 1'b0; mem_done = 1'b0; smp();
    checks++; if ({mem_en, if_stall, if_done} !== 3'b010) begin
      errors++; $display("FAIL prio_idle_gap: got en=%b ifst=%b ifd=%b want 0 1 0", mem_en, if_stall, if_done);
    end
    cyc(); smp();
    checks++; if ({mem_en, mem_addr, if_stall} !== {1'b1, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL prio_if_issue: got en=%b addr=%h ifst=%b want 1 0000 1", mem_en, mem_addr, if_stall);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'h0F0F; smp();
    checks++; if ({if_done, if_rdata, if_stall, dm_done} !== {1'b1, 16'h0F0F, 1'b0, 1'b0}) begin
      errors++; $display("FAIL prio_if_done: got ifd=%b rd=%h ifst=%b dmd=%b want 1 0f0f 0 0", if_done, if_rdata, if_stall, dm_done);
    end
    cyc(); if_req = 1'b0; mem_done = 1'b0; smp();
  endtask

  task automatic test_store_latency();
    int pulses = 0;
    cyc(); dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'hBEEF; smp();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k >= 2) begin dm_wdata = 16'h1111; dm_addr = 16'h0666; dm_wr = 1'b0; end
      mem_done = (k == 5);
      if (k == 6) dm_req = 1'b0;
      smp();
      checks++; if (mem_en !== (k == 1)) begin
        errors++; $display("FAIL st_en k=%0d: got %b want %b", k, mem_en, (k == 1));
      end
      checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0020, 16'hBEEF}) begin
        errors++; $display("FAIL st_hold k=%0d: got wr=%b addr=%h wd=%h want 1 0020 beef", k, mem_wr, mem_addr, mem_wdata);
      end
      checks++; if ({dm_done, if_done} !== {(k == 5), 1'b0}) begin
        errors++; $display("FAIL st_done k=%0d: got dmd=%b ifd=%b want %b 0", k, dm_done, if_done, (k == 5));
      end
      pulses += int'(dm_done);
    end
    checks++; if (pulses != 1) begin
      errors++; $display("FAIL st_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    cyc(); dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030; smp();
    cyc(); smp();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0030}) begin
      errors++; $display("FAIL rm_issue: got en=%b addr=%h want 1 0030", mem_en, mem_addr);
    end
    cyc(); rst = 1'b1; smp();
    checks++; if ({mem_en, mem_wr, mem_addr, mem_wdata, dm_done, dm_rdata, if_done, err, dm_stall} !== {51'd0, 1'b1}) begin
      errors++; $display("FAIL rm_reset_out: got en=%b addr=%h wd=%h dmd=%b err=%b dmst=%b want 0 0 0 0 0 1", mem_en, mem_addr, mem_wdata, dm_done, err, dm_stall);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'hAAAA; smp();
    checks++; if (dm_done !== 1'b0) begin
      errors++; $display("FAIL rm_no_done: got %b want 0", dm_done);
    end
    cyc(); rst = 1'b0; mem_done = 1'b0; smp();
    checks++; if ({mem_en, dm_done} !== 2'b00) begin
      errors++; $display("FAIL rm_idle: got en=%b dmd=%b want 0 0", mem_en, dm_done);
    end
    cyc(); smp();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0030}) begin
      errors++; $display("FAIL rm_reissue: got en=%b addr=%h want 1 0030", mem_en, mem_addr);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'hC0DE; smp();
    checks++; if ({dm_done, dm_rdata} !== {1'b1, 16'hC0DE}) begin
      errors++; $display("FAIL rm_done: got dmd=%b rd=%h want 1 c0de", dm_done, dm_rdata);
    end
    cyc(); dm_req = 1'b0; mem_done = 1'b0; smp();
  endtask

  task automatic test_misaligned();
    cyc(); dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0011; smp();
`ifdef MEM_ARB_ALIGN_CHK_EN
    cyc(); mem_rdata = 16'h9999; smp();
    checks++; if ({mem_en, dm_done, err, dm_rdata, if_done} !== {1'b0, 1'b1, 1'b1, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL mis_err: got en=%b dmd=%b err=%b rd=%h ifd=%b want 0 1 1 0000 0", mem_en, dm_done, err, dm_rdata, if_done);
    end
    cyc(); dm_req = 1'b0; smp();
    checks++; if ({err, dm_done, mem_en} !== 3'b000) begin
      errors++; $display("FAIL mis_after: got err=%b dmd=%b en=%b want 0 0 0", err, dm_done, mem_en);
    end
`else
    cyc(); smp();
    checks++; if ({mem_en, mem_addr, err} !== {1'b1, 16'h0011, 1'b0}) begin
      errors++; $display("FAIL mis_issue: got en=%b addr=%h err=%b want 1 0011 0", mem_en, mem_addr, err);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'h7777; smp();
    checks++; if ({dm_done, dm_rdata, err} !== {1'b1, 16'h7777, 1'b0}) begin
      errors++; $display("FAIL mis_done: got dmd=%b rd=%h err=%b want 1 7777 0", dm_done, dm_rdata, err);
    end
    cyc(); dm_req = 1'b0; mem_done = 1'b0; smp();
`endif
  endtask

  task automatic test_spurious_done();
    for (int k = 0; k < 3; k++) begin
      cyc(); mem_done = 1'b1; mem_rdata = 16'hDEAD; smp();
      checks++; if ({if_done, dm_done, mem_en} !== 3'b000) begin
        errors++; $display("FAIL sp_idle k=%0d: got ifd=%b dmd=%b en=%b want 0 0 0", k, if_done, dm_done, mem_en);
      end
    end
    cyc(); mem_done = 1'b0; if_req = 1'b1; if_addr = 16'h0042; smp();
    cyc(); smp();
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0042}) begin
      errors++; $display("FAIL sp_grant: got en=%b addr=%h want 1 0042", mem_en, mem_addr);
    end
    cyc(); mem_done = 1'b1; mem_rdata = 16'h4242; smp();
    checks++; if ({if_done, if_rdata} !== {1'b1, 16'h4242}) begin
      errors++; $display("FAIL sp_done: got ifd=%b rd=%h want 1 4242", if_done, if_rdata);
    end
    cyc(); if_req = 1'b0; mem_done = 1'b0; smp();
  endtask

  // Transaction-level model: phase 0 = arbiter free, 1 = issue cycle, 2 = awaiting memory.
  task automatic test_random();
    int          phase = 0;
    int          cnt = 0;
    bit          own_dm = 1'b0;
    bit          if_dprev = 1'b0;
    bit          dm_dprev = 1'b0;
    bit          real_done;
    bit          exp_ifd;
    bit          exp_dmd;
    logic [15:0] s_addr = 16'h0000;
    logic [15:0] s_wdata = 16'h0000;
    logic        s_wr = 1'b0;
    logic [15:0] exp_rd = 16'h0000;
    for (int i = 0; i < 256; i++) mm[i] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (if_dprev) begin
        if_req = ($urandom_range(0, 1) == 1); if_addr = 16'($urandom) & 16'hFFFE;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 16'($urandom) & 16'hFFFE;
      end
      if (dm_dprev) begin
        dm_req = ($urandom_range(0, 2) == 0); dm_wr = ($urandom_range(0, 1) == 1);
        dm_addr = 16'($urandom) & 16'hFFFE; dm_wdata = 16'($urandom);
      end else if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; dm_wr = ($urandom_range(0, 1) == 1);
        dm_addr = 16'($urandom) & 16'hFFFE; dm_wdata = 16'($urandom);
      end
      if (phase != 0 && $urandom_range(0, 3) == 0) begin
        if (own_dm) begin dm_addr = 16'($urandom) & 16'hFFFE; dm_wdata = 16'($urandom); dm_wr = ~dm_wr; end
        else if_addr = 16'($urandom) & 16'hFFFE;
      end
      real_done = 1'b0; mem_done = 1'b0;
      if (phase == 2) begin
        cnt--;
        if (cnt == 0) begin
          real_done = 1'b1; mem_done = 1'b1;
          exp_rd = s_wr ? 16'($urandom) : mm[s_addr[7:0]];
          mem_rdata = exp_rd;
          if (s_wr) mm[s_addr[7:0]] = s_wdata;
        end
      end else if (phase == 0 && $urandom_range(0, 7) == 0) begin
        mem_done = 1'b1; mem_rdata = 16'($urandom);
      end
      smp();
      exp_ifd = real_done & ~own_dm;
      exp_dmd = real_done & own_dm;
      checks++; if (mem_en !== (phase == 1)) begin
        errors++; $display("FAIL rnd_en c=%0d: got %b want %b", c, mem_en, (phase == 1));
      end
      checks++; if ({if_done, dm_done, err} !== {exp_ifd, exp_dmd, 1'b0}) begin
        errors++; $display("FAIL rnd_done c=%0d: got ifd=%b dmd=%b err=%b want %b %b 0", c, if_done, dm_done, err, exp_ifd, exp_dmd);
      end
      checks++; if ({if_stall, dm_stall} !== {if_req & ~exp_ifd, dm_req & ~exp_dmd}) begin
        errors++; $display("FAIL rnd_stall c=%0d: got %b%b want %b%b", c, if_stall, dm_stall, if_req & ~exp_ifd, dm_req & ~exp_dmd);
      end
      if (phase != 0) begin
        checks++; if ({mem_addr, mem_wr} !== {s_addr, s_wr}) begin
          errors++; $display("FAIL rnd_addr c=%0d: got addr=%h wr=%b want %h %b", c, mem_addr, mem_wr, s_addr, s_wr);
        end
        if (s_wr) begin
          checks++; if (mem_wdata !== s_wdata) begin
            errors++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, mem_wdata, s_wdata);
          end
        end
      end
      if (exp_ifd) begin
        checks++; if (if_rdata !== exp_rd) begin
          errors++; $display("FAIL rnd_if_rdata c=%0d: got %h want %h", c, if_rdata, exp_rd);
        end
      end
      if (exp_dmd && !s_wr) begin
        checks++; if (dm_rdata !== exp_rd) begin
          errors++; $display("FAIL rnd_dm_rdata c=%0d: got %h want %h", c, dm_rdata, exp_rd);
        end
      end
      if_dprev = exp_ifd;
      dm_dprev = exp_dmd;
      case (phase)
        0: begin
          if (dm_req) begin
            own_dm = 1'b1; s_addr = dm_addr; s_wr = dm_wr; s_wdata = dm_wdata; phase = 1;
          end else if (if_req) begin
            own_dm = 1'b0; s_addr = if_addr; s_wr = 1'b0; phase = 1;
          end
        end
        1: begin
          phase = 2; cnt = $urandom_range(1, 4);
        end
        default: if (real_done) phase = 0;
      endcase
    end
    cyc(); if_req = 1'b0; dm_req = 1'b0; mem_done = 1'b0; smp();
  endtask

  initial begin
    test_reset();
    test_if_basic();
    test_priority();
    test_store_latency();
    test_reset_mid();
    test_misaligned();
    test_spurious_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified memory between the fetch stage (read-only) and the memory stage (load/store) of the five-stage pipeline. Arbitrates one transaction at a time, drives the memory request for it, and holds the losing requester in stall until its own transaction completes. It sits between the FETCH/MEMORY stage units and the memory instance, and feeds the pipeline's stall logic.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; level, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid only while if_done=1
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  fetch must hold PC and inputs
- dm_req  in  1  data request; level, held until dm_done
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid only while dm_done=1
- dm_done  out  1  one-cycle completion pulse to the memory stage
- dm_stall  out  1  memory stage must hold
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write qualifier for the issued transaction
- mem_addr  out  ADDR_W  address, held stable from issue through mem_done
- mem_wdata  out  DATA_W  write data, held as mem_addr is
- mem_rdata  in  DATA_W  read data, valid with mem_done
- mem_done  in  1  memory completion, any number of cycles (>=1) after mem_en
- err  out  1  misaligned-access pulse (see Configuration)

## Operation
- States: IDLE, IF_WAIT, DM_WAIT, ERR_RSP.
- IDLE: dm_req=1 grants DM; otherwise if_req=1 grants IF. Data has fixed priority, since it belongs to the older instruction. On grant, at the next edge: latch address, write data and wr; enter X_WAIT; mem_en=1 for exactly that first WAIT cycle.
- X_WAIT: on mem_done=1, X_done=1 and X_rdata=mem_rdata in the same cycle (combinational). The next state is IDLE. Stores also receive X_done; dm_rdata is then don't-care.
- A request is never granted in the same cycle its done pulses. At least one IDLE cycle follows every transaction, during which requesters drop or renew req.
- if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done.
- mem_done in IDLE is ignored. if_req is never granted while dm_req is continuously high (starvation is intentional; the pipeline blocks fetch in that case).
- Requester inputs change mid-transaction: ignored, because issued values are latched.

## Timing
- Reset (async): state=IDLE. All outputs 0: mem_en, mem_wr, mem_addr, mem_wdata, done, rdata, err. Both stall outputs still follow their combinational equations, so they equal the current req.
- Reset asserted mid-transaction aborts it; no done pulse is produced.
- Minimum latency: req at cycle N → mem_en N+1 → mem_done N+2 → done N+2. Next grant is no earlier than N+3.
- Simultaneous if_req and dm_req in IDLE: DM is served first. IF is issued at the cycle after DM's done + 1 (IDLE cycle) + 1.
- mem_addr, mem_wdata and mem_wr hold their last value in IDLE.

## Configuration
- MEM_ARB_ALIGN_CHK_EN defined: a granted address with bit0=1 goes to ERR_RSP instead of X_WAIT. No mem_en is issued. The next cycle gives X_done=1, X_rdata=0 and err=1 (one cycle), then IDLE.
- MEM_ARB_ALIGN_CHK_EN undefined: no alignment check is performed; addresses pass unchanged, ERR_RSP is unreachable, and err is tied to 0.

## Structure
- mem_arb_pkg holds the state typedef (IDLE/IF_WAIT/DM_WAIT/ERR_RSP, 2-bit encoding) and the grant-owner constants GNT_IF and GNT_DM.
- Flat module: the FSM plus the latch registers. No sub-module is needed.

## Test plan
- Reset, then if_req=1 with if_addr=0x0000 and memory latency 1: mem_en at cycle 1, mem_addr=0x0000, if_done with if_rdata=mem_rdata (0x1234) at cycle 2, if_stall=0 at cycle 2.
- if_req and dm_req (load, addr 0x0010) rise in the same cycle: DM is issued first, dm_done arrives, then an IDLE cycle, then IF is issued with mem_addr=0x0000. if_stall stays high until if_done.
- Store dm_wr=1, addr 0x0020, wdata 0xBEEF, memory latency 4: mem_wr=1, mem_wdata=0xBEEF held for 4 cycles, dm_done pulses once, and no X_done appears in between.
- rst asserted during DM_WAIT: all outputs 0 immediately, no dm_done, and the next request is served normally after reset.
- With MEM_ARB_ALIGN_CHK_EN, dm load at addr 0x0011: no mem_en, dm_done=1, err=1, dm_rdata=0 one cycle after grant. Without the macro the access is issued to memory at 0x0011.
- A spurious mem_done in IDLE: no done pulse on either side and the state stays IDLE.
